// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store width
// codes and the access FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Stores only exist in signed-width form; loads add the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane extract/extend for loads and lane merge for stores, plus the
// access error decision. Macro DMEM_MISALIGN_TRAP_EN turns misaligned h/w accesses into errors.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged,
  output logic        o_err
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [31:0] w_word_b;
  logic [31:0] w_word_h;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_misalign;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_data;

  // Halfword position only looks at addr[1]; addr[0] is dropped unless trapped.
  assign w_bsh    = {i_addr_lo, 3'b000};
  assign w_hsh    = {i_addr_lo[1], 4'b0000};
  assign w_word_b = i_word >> w_bsh;
  assign w_word_h = i_word >> w_hsh;
  assign w_byte   = w_word_b[7:0];
  assign w_half   = w_word_h[15:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: w_misalign = i_addr_lo[0];
      F3_W:        w_misalign = |i_addr_lo;
      default:     w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign o_err = !f3_legal(i_we, i_funct3) || w_misalign;

  always_comb begin
    w_load = 32'h0;
    case (i_funct3)
      F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load = {{16{w_half[15]}}, w_half};
      F3_W:    w_load = i_word;
      F3_BU:   w_load = {24'h0, w_byte};
      F3_HU:   w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
  end

  assign o_load = (o_err || i_we) ? 32'h0 : w_load;

  always_comb begin
    w_mask = 32'h0;
    w_data = 32'h0;
    case (i_funct3)
      F3_B: begin
        w_mask = 32'h0000_00FF << w_bsh;
        w_data = {24'h0, i_wdata[7:0]} << w_bsh;
      end
      F3_H: begin
        w_mask = 32'h0000_FFFF << w_hsh;
        w_data = {16'h0, i_wdata[15:0]} << w_hsh;
      end
      F3_W: begin
        w_mask = 32'hFFFF_FFFF;
        w_data = i_wdata;
      end
      default: begin
        w_mask = 32'h0;
        w_data = 32'h0;
      end
    endcase
  end

  assign o_merged = (i_word & ~w_mask) | (w_data & w_mask);

endmodule

// File: rtl/dmem_resp.sv
// Wait-state data memory responder: captures one access, waits WAIT_CYCLES,
// pulses ready with rdata/err. Macro DMEM_MISALIGN_TRAP_EN enables misalignment errors.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT4 = WAIT_CYCLES[3:0];

  // Handshake: req is sampled only while IDLE; ready is a one-cycle pulse in
  // DONE and err/rdata are valid with it (held until the next DONE).
  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_capture;
  logic        w_enter_done;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [AW+1:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_sel_we;
  logic [2:0]    w_sel_funct3;
  logic [AW+1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_load;
  logic [31:0]   w_merged;
  logic          w_err;

  // With zero wait states DONE is entered on the capture edge, so the lane
  // logic must see the live request while IDLE and the captured one after.
  assign w_sel_we     = (r_state == ST_IDLE) ? we : r_we;
  assign w_sel_funct3 = (r_state == ST_IDLE) ? funct3 : r_funct3;
  assign w_sel_addr   = (r_state == ST_IDLE) ? addr[AW+1:0] : r_addr;
  assign w_sel_wdata  = (r_state == ST_IDLE) ? wdata : r_wdata;
  assign w_idx        = w_sel_addr[AW+1:2];
  assign w_word       = r_mem[w_idx];

  dmem_lane u_lane (
    .i_we      (w_sel_we),
    .i_funct3  (w_sel_funct3),
    .i_addr_lo (w_sel_addr[1:0]),
    .i_word    (w_word),
    .i_wdata   (w_sel_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged),
    .o_err     (w_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = WAIT4;
          w_state_nxt = (WAIT4 == 4'd0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_funct3 <= 3'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_we     <= we;
        r_funct3 <= funct3;
        r_addr   <= addr[AW+1:0];
        r_wdata  <= wdata;
      end
      if (w_enter_done) begin
        r_rdata <= w_load;
        r_err   <= w_err;
      end
    end
  end

  // Storage is never cleared; a store commits only on the edge leaving DONE.
  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_DONE && r_we && !r_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign rdata       = r_rdata;
  assign err         = r_err;
  assign ready       = (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed RV32I load/store cases, reset
// abort, back-to-back requests and random traffic against a byte-array model.
module tb_dmem_resp;

  localparam int DEPTH = 256;
  localparam int WAIT  = 1;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mbytes [0:4*DEPTH-1];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: memory as a byte array; accesses move 1/2/4 bytes.
  task automatic model_apply(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] rd, output logic e);
    int base, lo, nb;
    logic legal;
    logic mis;
    logic [31:0] v;
    base = int'((a >> 2) % DEPTH) * 4;
    lo   = int'(a[1:0]);
    if (w) legal = (f3 <= 3'd2);
    else   legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (legal && (lo % nb) != 0) mis = 1'b1;
`endif
    e  = !legal || mis;
    rd = 32'h0;
    if (e) return;
    lo = lo - (lo % nb);
    if (w) begin
      for (int i = 0; i < nb; i++) mbytes[base + lo + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mbytes[base + lo + i]) << (8*i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v;
    end
  endtask

  // Driver: one request, waits (bounded) for ready, returns cycle count
  // from the request cycle (lat=-1 on timeout) and ready one cycle later.
  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat, output logic rdy_after);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ready) lat = -1;
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_fill;
    logic [31:0] rd, md, d;
    logic e, me, ra;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_apply(1'b1, 3'd2, 32'(i*4), d, md, me);
      access(1'b1, 3'd2, 32'(i*4), d, rd, e, lat, ra);
      total++;
      if (e !== 1'b0 || lat != WAIT + 1) begin
        bad++; $display("FAIL fill_sw[%0d] err=%b lat=%0d want err=0 lat=%0d", i, e, lat, WAIT + 1);
      end
    end
  endtask

  typedef struct {
    logic w; logic [2:0] f3; logic [31:0] a; logic [31:0] d; logic [31:0] rd; logic e;
  } vec_t;

  task automatic test_directed;
    vec_t v[15];
    logic [31:0] rd, md;
    logic e, me, ra;
    int lat;
    v[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 3'd0, 32'h11,  32'h000000AA, 32'h0,        1'b0};
    v[3]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADAAEF, 1'b0};
    v[4]  = '{1'b0, 3'd0, 32'h11,  32'h0,        32'hFFFFFFAA, 1'b0};
    v[5]  = '{1'b0, 3'd4, 32'h11,  32'h0,        32'h000000AA, 1'b0};
    v[6]  = '{1'b1, 3'd1, 32'h22,  32'h00008001, 32'h0,        1'b0};
    v[7]  = '{1'b0, 3'd1, 32'h22,  32'h0,        32'hFFFF8001, 1'b0};
    v[8]  = '{1'b0, 3'd5, 32'h22,  32'h0,        32'h00008001, 1'b0};
    v[9]  = '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1};
    v[10] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADAAEF, 1'b0};
    v[11] = '{1'b1, 3'd4, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
    v[12] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADAAEF, 1'b0};
    v[13] = '{1'b0, 3'd2, 32'hF0000410, 32'h0,   32'hDEADAAEF, 1'b0};
    v[14] = '{1'b0, 3'd7, 32'h10,  32'h0,        32'h0,        1'b1};
    for (int i = 0; i < 15; i++) begin
      model_apply(v[i].w, v[i].f3, v[i].a, v[i].d, md, me);
      access(v[i].w, v[i].f3, v[i].a, v[i].d, rd, e, lat, ra);
      total++; if (lat != WAIT + 1) begin bad++; $display("FAIL dir_lat[%0d] got=%0d want=%0d", i, lat, WAIT + 1); end
      total++; if (rd !== v[i].rd) begin bad++; $display("FAIL dir_rdata[%0d] got=%h want=%h", i, rd, v[i].rd); end
      total++; if (e !== v[i].e) begin bad++; $display("FAIL dir_err[%0d] got=%b want=%b", i, e, v[i].e); end
      total++; if (ra !== 1'b0) begin bad++; $display("FAIL dir_pulse[%0d] ready still high", i); end
    end
  endtask

  task automatic test_misalign;
    logic [31:0] rd, md;
    logic e, me, ra;
    int lat;
    model_apply(1'b0, 3'd2, 32'h13, 32'h0, md, me);
    access(1'b0, 3'd2, 32'h13, 32'h0, rd, e, lat, ra);
`ifdef DMEM_MISALIGN_TRAP_EN
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_lw got=%h/%b want=0/1", rd, e); end
`else
    total++; if (e !== 1'b0 || rd !== 32'hDEADAAEF) begin bad++; $display("FAIL mis_lw got=%h/%b want=deadaaef/0", rd, e); end
`endif
    model_apply(1'b1, 3'd1, 32'h23, 32'h00001234, md, me);
    access(1'b1, 3'd1, 32'h23, 32'h00001234, rd, e, lat, ra);
    model_apply(1'b0, 3'd5, 32'h22, 32'h0, md, me);
    access(1'b0, 3'd5, 32'h22, 32'h0, rd, e, lat, ra);
`ifdef DMEM_MISALIGN_TRAP_EN
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL mis_sh got=%h want=00008001", rd); end
`else
    total++; if (rd !== 32'h00001234) begin bad++; $display("FAIL mis_sh got=%h want=00001234", rd); end
`endif
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, md;
    logic e, me, ra;
    int lat;
    int seen;
    model_apply(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, md, me);
    access(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, rd, e, lat, ra);
    model_apply(1'b0, 3'd0, 32'h11, 32'h0, md, me);
    access(1'b0, 3'd0, 32'h11, 32'h0, rd, e, lat, ra);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h30; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    total++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL abort_outputs got ready=%b err=%b rdata=%h want 0/0/0", ready, err, rdata);
    end
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_ready got=%0d pulses want=0", seen); end
    model_apply(1'b0, 3'd2, 32'h30, 32'h0, md, me);
    access(1'b0, 3'd2, 32'h30, 32'h0, rd, e, lat, ra);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_mem got=%h want=cafef00d", rd); end
  endtask

  // req held high: pulses every WAIT+2 cycles, first at cycle WAIT+1.
  task automatic test_back_to_back;
    logic [31:0] md;
    logic me, want;
    int n;
    model_apply(1'b0, 3'd2, 32'h10, 32'h0, md, me);
    n = 1 + WAIT + 2*(WAIT + 2);
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h10; wdata = 32'h0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      want = (k >= 1 + WAIT) && (((k - 1 - WAIT) % (WAIT + 2)) == 0);
      total++; if (ready !== want) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", k, ready, want); end
      if (want) begin
        total++; if (rdata !== md) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h want=%h", k, rdata, md); end
      end
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [31:0] rd, md, a, d, exp_rd;
    logic e, me, ra, w, exp_e;
    logic [2:0] f3;
    int lat;
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      d  = $urandom;
      model_apply(w, f3, a, d, md, me);
      exp_q.push_back(md);
      exp_err_q.push_back(me);
      access(w, f3, a, d, rd, e, lat, ra);
      exp_rd = exp_q.pop_front();
      exp_e  = exp_err_q.pop_front();
      total++;
      if (rd !== exp_rd || e !== exp_e || lat != WAIT + 1) begin
        bad++;
        $display("FAIL rnd[%0d] we=%b f3=%0d addr=%h got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 i, w, f3, a, rd, e, lat, exp_rd, exp_e, WAIT + 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    test_reset;
    test_fill;
    test_directed;
    test_misalign;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
